exc_commit_unit: RTL and testbench

EXC_COMMIT_UNIT -- requirements
Module: exc_commit_unit

---
 rtl/exc_pkg.sv | 39 +++
 rtl/exc_commit_unit_if.sv | 17 +
 rtl/exc_prio_enc.sv | 20 ++
 rtl/exc_commit_unit.sv | 155 +++++++++++++++
 tb/tb_exc_commit_unit.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_pkg.sv
// Shared constants and types for the exception commit unit: ExcCodes,
// exception vector base/offsets and the commit FSM state encoding.
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] VEC_BASE_BEV   = 32'hBFC0_0200;
    localparam logic [31:0] VEC_BASE_NORM  = 32'h8000_0000;
    localparam logic [31:0] VEC_OFF_REFILL = 32'h0000_0000;
    localparam logic [31:0] VEC_OFF_IRQ    = 32'h0000_0200;
    localparam logic [31:0] VEC_OFF_GEN    = 32'h0000_0180;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } exc_state_e;

    // Full 32-bit vector; callers truncate to their address width.
    function automatic logic [31:0] exc_vector(input logic bev, input logic refill,
                                               input logic irq_iv);
        logic [31:0] base;
        logic [31:0] off;
        base = bev ? VEC_BASE_BEV : VEC_BASE_NORM;
        if (refill)      off = VEC_OFF_REFILL;
        else if (irq_iv) off = VEC_OFF_IRQ;
        else             off = VEC_OFF_GEN;
        return base + off;
    endfunction

endpackage

// File: rtl/exc_commit_unit_if.sv
// COP0 record channel: the unit holds valid with a frozen record until the
// consumer raises ready; the record transfers on the edge where both are high.
interface exc_commit_unit_if #(
    parameter int ADDR_W = 32
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] epc;
    logic [ADDR_W-1:0] badva;
    logic [4:0]        code;
    logic              bd;
    logic              epc_we;
    logic              badva_we;

    modport master (output valid, epc, badva, code, bd, epc_we, badva_we, input ready);
    modport slave  (input valid, epc, badva, code, bd, epc_we, badva_we, output ready);
endinterface

// File: rtl/exc_prio_enc.sv
// Oldest-first priority encoder: reports the highest-index set request.
module exc_prio_enc #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/exc_commit_unit.sv
// Picks the oldest pipeline exception (or a pending interrupt), redirects
// fetch, and hands the committed record to COP0 over a valid/ready channel.
module exc_commit_unit
    import exc_pkg::*;
#(
    parameter int NUM_STAGE = 3,
    parameter int NUM_IRQ   = 8,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic [NUM_STAGE-1:0]        exc_valid,
    input  logic [5*NUM_STAGE-1:0]      exc_code,
    input  logic [NUM_STAGE-1:0]        exc_refill,
    input  logic [ADDR_W*NUM_STAGE-1:0] stage_pc,
    input  logic [ADDR_W*NUM_STAGE-1:0] stage_badva,
    input  logic [NUM_STAGE-1:0]        stage_bd,
    input  logic [NUM_STAGE-1:0]        badva_vld,
    input  logic [NUM_STAGE-1:0]        pipe_flush,
    input  logic                        eret,
    input  logic [NUM_IRQ-1:0]          irq,
    input  logic [NUM_IRQ-1:0]          status_im,
    input  logic                        status_ie,
    input  logic                        status_exl,
    input  logic                        status_erl,
    input  logic                        status_bev,
    input  logic                        cause_iv,
    input  logic [ADDR_W-1:0]           epc_in,
    input  logic [ADDR_W-1:0]           error_epc_in,
    output logic [NUM_STAGE-1:0]        flush,
    output logic [ADDR_W-1:0]           exc_pc,
    output logic                        use_exc_pc,
    output logic                        busy,
    output exc_state_e                  state_dbg,
    exc_commit_unit_if.master           cp0
);
    localparam int IDX_W = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1;

    logic [NUM_IRQ-1:0]   irq_meta, irq_sync;
    logic [NUM_STAGE-1:0] req, kill_mask;
    logic [IDX_W-1:0]     win_idx;
    logic                 found, irq_req, eret_take, accept;
    exc_state_e           state, state_next;

    logic [ADDR_W-1:0]    sel_pc, sel_badva, vec_pc, new_epc;
    logic [4:0]           sel_code;
    logic                 sel_refill, sel_bd, sel_badva_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_meta <= '0;
            irq_sync <= '0;
        end else begin
            irq_meta <= irq;
            irq_sync <= irq_meta;
        end
    end

    assign req       = exc_valid & ~pipe_flush;
    assign irq_req   = (|(irq_sync & status_im)) & status_ie & ~status_exl & ~status_erl;
    assign eret_take = eret & ~pipe_flush[NUM_STAGE-1];

    exc_prio_enc #(.N(NUM_STAGE), .IDX_W(IDX_W)) u_prio (
        .req   (req),
        .idx   (win_idx),
        .found (found)
    );

    // An interrupt-only winner shows up as stage 0 with found low.
    always_comb begin
        sel_pc        = '0;
        sel_badva     = '0;
        sel_code      = '0;
        sel_refill    = 1'b0;
        sel_bd        = 1'b0;
        sel_badva_vld = 1'b0;
        for (int i = 0; i < NUM_STAGE; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_pc        = stage_pc[i*ADDR_W +: ADDR_W];
                sel_badva     = stage_badva[i*ADDR_W +: ADDR_W];
                sel_code      = exc_code[i*5 +: 5];
                sel_refill    = exc_refill[i];
                sel_bd        = stage_bd[i];
                sel_badva_vld = badva_vld[i];
            end
        end
        if (!found) begin
            sel_code      = EXC_INT;
            sel_refill    = 1'b0;
            sel_badva_vld = 1'b0;
        end
        for (int j = 0; j < NUM_STAGE; j++) begin
            kill_mask[j] = (IDX_W'(j) <= win_idx);
        end
    end

    assign vec_pc  = ADDR_W'(exc_vector(status_bev, sel_refill & ~status_exl, ~found & cause_iv));
    assign new_epc = sel_bd ? (sel_pc - ADDR_W'(4)) : sel_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        flush      = '0;
        use_exc_pc = 1'b0;
        exc_pc     = '0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst && !stall) begin
                    if (eret_take) begin
                        flush      = '1;
                        use_exc_pc = 1'b1;
                        exc_pc     = status_erl ? error_epc_in : epc_in;
                    end else if (found || irq_req) begin
                        accept     = 1'b1;
                        flush      = kill_mask;
                        use_exc_pc = 1'b1;
                        exc_pc     = vec_pc;
                        state_next = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: if (cp0.ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cp0.epc      <= '0;
            cp0.badva    <= '0;
            cp0.code     <= '0;
            cp0.bd       <= 1'b0;
            cp0.epc_we   <= 1'b0;
            cp0.badva_we <= 1'b0;
        end else if (accept) begin
            cp0.epc      <= new_epc;
            cp0.badva    <= sel_badva;
            cp0.code     <= sel_code;
            cp0.bd       <= sel_bd;
            cp0.epc_we   <= ~status_exl;
            cp0.badva_we <= sel_badva_vld;
        end
    end

    assign cp0.valid = (state == ST_COMMIT);
    assign busy      = (state == ST_COMMIT);
    assign state_dbg = state;

endmodule

// File: tb/tb_exc_commit_unit.sv
// Bench for exc_commit_unit: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a behavioural reference model.
module tb_exc_commit_unit;
    import exc_pkg::*;

    localparam int NS = 3;
    localparam int NI = 8;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            stall, eret;
    logic [NS-1:0]   exc_valid, exc_refill, stage_bd, badva_vld, pipe_flush;
    logic [5*NS-1:0] exc_code;
    logic [AW*NS-1:0] stage_pc, stage_badva;
    logic [NI-1:0]   irq, status_im;
    logic            status_ie, status_exl, status_erl, status_bev, cause_iv;
    logic [AW-1:0]   epc_in, error_epc_in;
    logic [NS-1:0]   flush;
    logic [AW-1:0]   exc_pc;
    logic            use_exc_pc, busy;
    exc_state_e      state_dbg;

    exc_commit_unit_if #(.ADDR_W(AW)) cp0_bus ();

    exc_commit_unit #(.NUM_STAGE(NS), .NUM_IRQ(NI), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_refill(exc_refill), .stage_pc(stage_pc), .stage_badva(stage_badva),
        .stage_bd(stage_bd), .badva_vld(badva_vld), .pipe_flush(pipe_flush), .eret(eret),
        .irq(irq), .status_im(status_im), .status_ie(status_ie), .status_exl(status_exl),
        .status_erl(status_erl), .status_bev(status_bev), .cause_iv(cause_iv),
        .epc_in(epc_in), .error_epc_in(error_epc_in), .flush(flush), .exc_pc(exc_pc),
        .use_exc_pc(use_exc_pc), .busy(busy), .state_dbg(state_dbg), .cp0(cp0_bus.master)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int errors = 0;
    int checks = 0;
    logic [36:0] exp_q[$];
    logic [NI-1:0] irq_hist[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; eret = 0; exc_valid = '0; exc_code = '0; exc_refill = '0;
        stage_pc = '0; stage_badva = '0; stage_bd = '0; badva_vld = '0; pipe_flush = '0;
        irq = '0; status_im = '0; status_ie = 0; status_exl = 0; status_erl = 0;
        status_bev = 0; cause_iv = 0; epc_in = '0; error_epc_in = '0;
        cp0_bus.ready = 0;
    endtask

    task automatic finish_commit(input string name);
        @(negedge clk);
        exc_valid = '0; eret = 0; cp0_bus.ready = 1;
        @(posedge clk); #1;
        check({name, "_ret_idle"}, busy, 0);
        cp0_bus.ready = 0;
    endtask

    typedef struct {
        logic [2:0]  valid, pflush, refill, bd, bvld;
        logic [14:0] code;
        logic [95:0] pc;
        logic        bev, exl;
        logic [2:0]  exp_flush;
        logic [31:0] exp_pc;
        logic [4:0]  exp_code;
        logic [31:0] exp_epc;
        logic        exp_bd, exp_bvwe, exp_epcwe;
        int          exp_k;
    } vec_t;

    function automatic vec_t mk(logic [2:0] v, logic [2:0] pf, logic [2:0] rf, logic [2:0] bd,
                                logic [2:0] bv, logic [14:0] c, logic [95:0] pc, logic bev,
                                logic exl, logic [2:0] ef, logic [31:0] ep, logic [4:0] ec,
                                logic [31:0] ee, logic eb, logic ebv, logic eew, int k);
        vec_t r;
        r.valid = v; r.pflush = pf; r.refill = rf; r.bd = bd; r.bvld = bv; r.code = c;
        r.pc = pc; r.bev = bev; r.exl = exl; r.exp_flush = ef; r.exp_pc = ep; r.exp_code = ec;
        r.exp_epc = ee; r.exp_bd = eb; r.exp_bvwe = ebv; r.exp_epcwe = eew; r.exp_k = k;
        return r;
    endfunction

    vec_t vt[6];

    // reference-model scratch
    logic [2:0]  m_flush;
    logic        m_use, m_acc, m_busy, irqw;
    logic [31:0] m_pc, m_base, m_off, r_epc;
    logic [4:0]  r_code;
    logic [NI-1:0] m_sync;
    logic [36:0] sb_exp;
    int          k, kk;

    initial begin
        vt[0] = mk(3'b011, 3'b000, 3'b000, 3'b000, 3'b000, {5'd0, 5'd8, 5'd10},
                   {32'h00400008, 32'h00400004, 32'h00400000}, 0, 0,
                   3'b011, 32'h80000180, 5'd8, 32'h00400004, 0, 0, 1, 1);
        vt[1] = mk(3'b100, 3'b000, 3'b100, 3'b100, 3'b100, {5'd2, 5'd0, 5'd0},
                   {32'h00400104, 32'h00400100, 32'h004000FC}, 0, 0,
                   3'b111, 32'h80000000, 5'd2, 32'h00400100, 1, 1, 1, 2);
        vt[2] = mk(3'b001, 3'b000, 3'b001, 3'b000, 3'b001, {5'd0, 5'd0, 5'd4},
                   {32'h0, 32'h0, 32'h00001000}, 1, 1,
                   3'b001, 32'hBFC00380, 5'd4, 32'h00001000, 0, 1, 0, 0);
        vt[3] = mk(3'b110, 3'b100, 3'b000, 3'b010, 3'b100, {5'd8, 5'd12, 5'd0},
                   {32'h00005000, 32'h00002000, 32'h0}, 0, 0,
                   3'b011, 32'h80000180, 5'd12, 32'h00001FFC, 1, 0, 1, 1);
        vt[4] = mk(3'b010, 3'b000, 3'b010, 3'b000, 3'b010, {5'd0, 5'd3, 5'd0},
                   {32'h0, 32'h00003000, 32'h0}, 1, 0,
                   3'b011, 32'hBFC00200, 5'd3, 32'h00003000, 0, 1, 1, 1);
        vt[5] = mk(3'b111, 3'b000, 3'b000, 3'b100, 3'b000, {5'd9, 5'd1, 5'd2},
                   {32'h00000000, 32'h00000010, 32'h00000020}, 0, 0,
                   3'b111, 32'h80000180, 5'd9, 32'hFFFFFFFC, 1, 0, 1, 2);

        // reset state
        clear_inputs();
        exc_valid = 3'b001;
        #3;
        check("rst_flush", flush, 0);
        check("rst_use", use_exc_pc, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", cp0_bus.valid, 0);
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_epc", cp0_bus.epc, 0);
        check("rst_code", cp0_bus.code, 0);
        @(negedge clk);
        rst = 1; exc_valid = '0;

        // vector table
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            exc_valid = vt[t].valid; pipe_flush = vt[t].pflush; exc_refill = vt[t].refill;
            stage_bd = vt[t].bd; badva_vld = vt[t].bvld; exc_code = vt[t].code;
            stage_pc = vt[t].pc; status_bev = vt[t].bev; status_exl = vt[t].exl;
            stage_badva = {32'hB0000002, 32'hB0000001, 32'hB0000000};
            #1;
            check($sformatf("vec%0d_flush", t), flush, vt[t].exp_flush);
            check($sformatf("vec%0d_use", t), use_exc_pc, 1);
            check($sformatf("vec%0d_pc", t), exc_pc, vt[t].exp_pc);
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", t), cp0_bus.valid, 1);
            check($sformatf("vec%0d_code", t), cp0_bus.code, vt[t].exp_code);
            check($sformatf("vec%0d_epc", t), cp0_bus.epc, vt[t].exp_epc);
            check($sformatf("vec%0d_bd", t), cp0_bus.bd, vt[t].exp_bd);
            check($sformatf("vec%0d_bvwe", t), cp0_bus.badva_we, vt[t].exp_bvwe);
            check($sformatf("vec%0d_epcwe", t), cp0_bus.epc_we, vt[t].exp_epcwe);
            check($sformatf("vec%0d_badva", t), cp0_bus.badva, 32'hB0000000 + 32'(vt[t].exp_k));
            finish_commit($sformatf("vec%0d", t));
            clear_inputs();
        end

        // stall holds off acceptance
        @(negedge clk);
        stall = 1; exc_valid = 3'b010; exc_code = {5'd0, 5'd8, 5'd0};
        #1;
        check("stall_flush", flush, 0);
        check("stall_use", use_exc_pc, 0);
        @(posedge clk); #1;
        check("stall_state", state_dbg, ST_IDLE);
        @(negedge clk);
        stall = 0;
        #1;
        check("unstall_flush", flush, 3'b011);
        check("unstall_use", use_exc_pc, 1);
        @(posedge clk); #1;
        check("unstall_code", cp0_bus.code, 8);
        finish_commit("unstall");
        clear_inputs();

        // interrupt through the synchronizer
        @(negedge clk);
        status_ie = 1; status_im = 8'h08; cause_iv = 1; irq = 8'h08;
        #1;
        check("irq_edge0_use", use_exc_pc, 0);
        @(posedge clk); #1;
        check("irq_edge1_use", use_exc_pc, 0);
        @(posedge clk); #1;
        check("irq_edge2_use", use_exc_pc, 1);
        check("irq_pc", exc_pc, 32'h80000200);
        check("irq_flush", flush, 3'b001);
        @(posedge clk); #1;
        check("irq_valid", cp0_bus.valid, 1);
        check("irq_code", cp0_bus.code, 0);
        irq = '0; status_ie = 0;
        finish_commit("irq");
        clear_inputs();
        repeat (3) @(posedge clk);

        // COMMIT held while cp0 is not ready
        @(negedge clk);
        exc_valid = 3'b001; exc_code = {5'd0, 5'd0, 5'd10}; stage_pc = {64'h0, 32'h00001000};
        @(posedge clk); #1;
        check("hold_enter", cp0_bus.valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exc_valid = 3'($urandom_range(1, 7)); exc_code = 15'($urandom);
            stage_pc = {$urandom, $urandom, $urandom};
            #1;
            check($sformatf("hold%0d_flush", c), flush, 0);
            check($sformatf("hold%0d_use", c), use_exc_pc, 0);
            check($sformatf("hold%0d_busy", c), busy, 1);
            check($sformatf("hold%0d_code", c), cp0_bus.code, 10);
            check($sformatf("hold%0d_epc", c), cp0_bus.epc, 32'h00001000);
        end
        @(negedge clk);
        cp0_bus.ready = 1; exc_valid = '0;
        #1;
        check("hold_busy_before_edge", busy, 1);
        @(posedge clk); #1;
        check("hold_release", state_dbg, ST_IDLE);
        clear_inputs();

        // ERET wins over a concurrent exception
        @(negedge clk);
        eret = 1; status_erl = 1; error_epc_in = 32'hBFC00000; epc_in = 32'h12345678;
        exc_valid = 3'b001;
        #1;
        check("eret_flush", flush, 3'b111);
        check("eret_use", use_exc_pc, 1);
        check("eret_pc", exc_pc, 32'hBFC00000);
        @(posedge clk); #1;
        check("eret_no_commit", cp0_bus.valid, 0);
        clear_inputs();
        repeat (3) @(posedge clk);

        // randomized traffic vs reference model
        m_busy = 0;
        irq_hist.delete();
        irq_hist.push_back('0);
        irq_hist.push_back('0);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            stall = ($urandom_range(0, 3) == 0);
            exc_valid = $urandom_range(0, 1) ? 3'($urandom) : 3'b0;
            pipe_flush = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0;
            eret = ($urandom_range(0, 7) == 0);
            exc_code = 15'($urandom); exc_refill = 3'($urandom);
            stage_bd = 3'($urandom); badva_vld = 3'($urandom);
            for (int s = 0; s < NS; s++) begin
                stage_pc[s*AW +: AW] = $urandom & 32'hFFFFFFFC;
                stage_badva[s*AW +: AW] = $urandom;
            end
            irq = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
            status_im = 8'($urandom);
            status_ie = ($urandom_range(0, 3) != 0);
            status_exl = ($urandom_range(0, 3) == 0);
            status_erl = ($urandom_range(0, 7) == 0);
            status_bev = 1'($urandom); cause_iv = 1'($urandom);
            epc_in = $urandom; error_epc_in = $urandom;
            cp0_bus.ready = ($urandom_range(0, 2) == 0);
            irq_hist.push_back(irq);
            m_sync = irq_hist.pop_front();
            #1;
            m_flush = 0; m_use = 0; m_pc = 0; m_acc = 0;
            if (!m_busy && !stall) begin
                if (eret && !pipe_flush[NS-1]) begin
                    m_flush = 3'b111; m_use = 1;
                    m_pc = status_erl ? error_epc_in : epc_in;
                end else begin
                    k = -1;
                    for (int s = NS - 1; s >= 0 && k < 0; s--)
                        if (exc_valid[s] && !pipe_flush[s]) k = s;
                    irqw = (k < 0) && ((m_sync & status_im) != 0) && status_ie &&
                           !status_exl && !status_erl;
                    if (k >= 0 || irqw) begin
                        m_acc = 1; m_use = 1;
                        kk = (k < 0) ? 0 : k;
                        for (int s = 0; s <= kk; s++) m_flush[s] = 1;
                        m_base = status_bev ? 32'hBFC00200 : 32'h80000000;
                        if (k >= 0 && exc_refill[k] && !status_exl) m_off = 32'h0;
                        else if (irqw && cause_iv) m_off = 32'h200;
                        else m_off = 32'h180;
                        m_pc = m_base + m_off;
                        r_code = irqw ? 5'd0 : exc_code[kk*5 +: 5];
                        r_epc = stage_pc[kk*AW +: AW] - (stage_bd[kk] ? 32'd4 : 32'd0);
                    end
                end
            end
            check($sformatf("rnd%0d_flush", n), flush, m_flush);
            check($sformatf("rnd%0d_use", n), use_exc_pc, m_use);
            check($sformatf("rnd%0d_pc", n), exc_pc, m_pc);
            check($sformatf("rnd%0d_busy", n), busy, m_busy);
            if (m_busy && cp0_bus.ready) begin
                check($sformatf("rnd%0d_sb_nonempty", n), exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    sb_exp = exp_q.pop_front();
                    check($sformatf("rnd%0d_record", n), {cp0_bus.epc, cp0_bus.code}, sb_exp);
                end
            end
            @(posedge clk);
            if (m_acc) begin
                m_busy = 1;
                exp_q.push_back({r_epc, r_code});
            end else if (m_busy && cp0_bus.ready) begin
                m_busy = 0;
            end
        end

        // reset asserted mid-commit
        clear_inputs();
        @(negedge clk);
        if (busy) cp0_bus.ready = 1;
        @(negedge clk);
        cp0_bus.ready = 0;
        exc_valid = 3'b010; exc_code = {5'd0, 5'd9, 5'd0};
        @(posedge clk); #1;
        check("rstc_enter", cp0_bus.valid, 1);
        #2;
        rst = 0;
        #1;
        check("rstc_valid", cp0_bus.valid, 0);
        check("rstc_state", state_dbg, ST_IDLE);
        check("rstc_flush", flush, 0);
        check("rstc_code", cp0_bus.code, 0);
        @(negedge clk);
        rst = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
